// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the PDP-11 memory port
//               arbiter: FSM states, requester ids, byte-enable codes and
//               the odd-address classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_OPR   = 2'd1,
        REQ_WB    = 2'd2
    } mem_req_id_t;

    // Trap vector the downstream trap logic uses for odd-address errors.
    localparam logic [15:0] ODD_ADDR_TRAP_VEC = 16'o4;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LOW  = 2'b01;
    localparam logic [1:0] BE_HIGH = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    // True when the access cannot be issued because the byte address does
    // not match the lanes being touched. Reads are always whole words.
    function automatic logic odd_access(input logic       is_write,
                                        input logic [1:0] be,
                                        input logic       addr0);
        logic bad;
        bad = 1'b0;
        if (!is_write) begin
            bad = addr0;
        end else begin
            case (be)
                BE_WORD: bad = addr0;
                BE_LOW:  bad = addr0;
                BE_HIGH: bad = !addr0;
                default: bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of requester handshakes and memory-side bus for the
//               memory port arbiter. The slave modport is the arbiter's
//               view; the master modport is the pipeline/memory view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_flush;
    logic              fetch_gnt;
    logic              fetch_rvalid;

    logic              opr_req;
    logic [ADDR_W-1:0] opr_addr;
    logic              opr_gnt;
    logic              opr_rvalid;

    logic [DATA_W-1:0] rdata;

    logic              wb_req;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_wdata;
    logic [1:0]        wb_be;
    logic              wb_gnt;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-2:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;

    logic              odd_err;
    logic [1:0]        odd_err_src;

    modport slave (
        input  fetch_req, fetch_addr, fetch_flush,
        output fetch_gnt, fetch_rvalid,
        input  opr_req, opr_addr,
        output opr_gnt, opr_rvalid,
        output rdata,
        input  wb_req, wb_addr, wb_wdata, wb_be,
        output wb_gnt,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata,
        output odd_err, odd_err_src
    );

    modport master (
        output fetch_req, fetch_addr, fetch_flush,
        input  fetch_gnt, fetch_rvalid,
        output opr_req, opr_addr,
        input  opr_gnt, opr_rvalid,
        input  rdata,
        output wb_req, wb_addr, wb_wdata, wb_be,
        input  wb_gnt,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata,
        input  odd_err, odd_err_src
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_priority_sel.sv
`default_nettype none
// ============================================================================
// Module      : arb_priority_sel
// Description : Combinational priority picker. Normal order is
//               writeback > operand > fetch; when the fetch starvation flag
//               is raised and fetch is requesting, fetch wins outright.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_priority_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,        // bit index = mem_req_id_t
    input  logic               starve,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output mem_req_id_t        gnt_id,
    output logic               gnt_any
);

    // Pick exactly one requester in fixed priority, with the fetch override.
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = REQ_FETCH;
        gnt_any    = |req;
        if (starve && req[REQ_FETCH]) begin
            gnt_onehot[REQ_FETCH] = 1'b1;
            gnt_id                = REQ_FETCH;
        end else if (req[REQ_WB]) begin
            gnt_onehot[REQ_WB] = 1'b1;
            gnt_id             = REQ_WB;
        end else if (req[REQ_OPR]) begin
            gnt_onehot[REQ_OPR] = 1'b1;
            gnt_id              = REQ_OPR;
        end else if (req[REQ_FETCH]) begin
            gnt_onehot[REQ_FETCH] = 1'b1;
            gnt_id                = REQ_FETCH;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single PDP-11 memory port between instruction
//               fetch, operand read and writeback. One transaction in flight,
//               fixed priority with fetch aging, odd-address error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);

    localparam int                LAT_W      = 3;
    localparam int                STV_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0]  LAT_LAST   = MEM_LATENCY[LAT_W-1:0];
    localparam logic [STV_W-1:0]  STARVE_MAX = STARVE_LIMIT[STV_W-1:0];

    arb_state_t         state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    mem_req_id_t        owner_q, owner_d;
    logic               flush_q, flush_d;
    logic [STV_W-1:0]   starve_cnt_q, starve_cnt_d;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] sel_onehot;
    mem_req_id_t        sel_id;
    logic               sel_any;
    logic               starve_hit;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_is_write;
    logic               sel_odd;

    assign req_vec    = {bus.wb_req, bus.opr_req, bus.fetch_req};
    assign starve_hit = (starve_cnt_q == STARVE_MAX);

    arb_priority_sel u_prio (
        .req        (req_vec),
        .starve     (starve_hit),
        .gnt_onehot (sel_onehot),
        .gnt_id     (sel_id),
        .gnt_any    (sel_any)
    );

    // Next-state, grant and memory-strobe decode; everything is held at zero
    // while rst_n is low so an abandoned read never produces an rvalid.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        owner_d      = owner_q;
        flush_d      = flush_q;
        starve_cnt_d = starve_cnt_q;

        bus.fetch_gnt    = 1'b0;
        bus.opr_gnt      = 1'b0;
        bus.wb_gnt       = 1'b0;
        bus.fetch_rvalid = 1'b0;
        bus.opr_rvalid   = 1'b0;
        bus.rdata        = '0;
        bus.mem_en       = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.mem_be       = BE_NONE;
        bus.odd_err      = 1'b0;
        bus.odd_err_src  = REQ_FETCH;

        sel_addr     = '0;
        sel_is_write = 1'b0;
        sel_odd      = 1'b0;

        if (rst_n) begin
            case (state_q)
                ARB_IDLE: begin
                    if (sel_any) begin
                        {bus.wb_gnt, bus.opr_gnt, bus.fetch_gnt} = sel_onehot;
                        case (sel_id)
                            REQ_WB:  sel_addr = bus.wb_addr;
                            REQ_OPR: sel_addr = bus.opr_addr;
                            default: sel_addr = bus.fetch_addr;
                        endcase
                        sel_is_write = (sel_id == REQ_WB);
                        sel_odd      = odd_access(sel_is_write, bus.wb_be, sel_addr[0]);

                        if (sel_odd) begin
                            bus.odd_err     = 1'b1;
                            bus.odd_err_src = sel_id;
                        end else if (sel_is_write) begin
                            // Empty byte-enable is a no-op grant: nothing reaches memory.
                            if (bus.wb_be != BE_NONE) begin
                                bus.mem_en    = 1'b1;
                                bus.mem_we    = 1'b1;
                                bus.mem_be    = bus.wb_be;
                                bus.mem_addr  = sel_addr[ADDR_W-1:1];
                                bus.mem_wdata = bus.wb_wdata;
                            end
                        end else begin
                            bus.mem_en   = 1'b1;
                            bus.mem_be   = BE_WORD;
                            bus.mem_addr = sel_addr[ADDR_W-1:1];
                            state_d      = ARB_WAIT;
                            lat_cnt_d    = LAT_W'(1);
                            owner_d      = sel_id;
                            flush_d      = 1'b0;
                        end

                        // Fetch ages only when it was asking and someone else won.
                        if (sel_id == REQ_FETCH) begin
                            starve_cnt_d = '0;
                        end else if (bus.fetch_req && !starve_hit) begin
                            starve_cnt_d = starve_cnt_q + STV_W'(1);
                        end
                    end
                end

                ARB_WAIT: begin
                    flush_d = flush_q | ((owner_q == REQ_FETCH) && bus.fetch_flush);
                    if (lat_cnt_q == LAT_LAST) begin
                        state_d   = ARB_IDLE;
                        lat_cnt_d = '0;
                        if (owner_q == REQ_OPR) begin
                            bus.opr_rvalid = 1'b1;
                            bus.rdata      = bus.mem_rdata;
                        end else if (!flush_d) begin
                            bus.fetch_rvalid = 1'b1;
                            bus.rdata        = bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    end
                end

                default: state_d = ARB_IDLE;
            endcase
        end
    end

    // State, latency counter, read owner, flush flag and fetch aging counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            lat_cnt_q    <= '0;
            owner_q      <= REQ_FETCH;
            flush_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            owner_q      <= owner_d;
            flush_q      <= flush_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // An empty byte-enable write is a pipeline bug; it is granted as a no-op.
    a_wb_be_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        bus.wb_gnt |-> (bus.wb_be != BE_NONE));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Bench for mem_port_arbiter. Two instances (latency 2 and 3)
//               share one stimulus stream; a transaction-level model predicts
//               every output each cycle, plus directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        fetch_req, fetch_flush, opr_req, wb_req;
    logic [15:0] fetch_addr, opr_addr, wb_addr, wb_wdata, mem_rdata;
    logic [1:0]  wb_be;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Model state per instance: k=0 is latency 2, k=1 is latency 3.
    int       m_left   [2];   // cycles until outstanding read returns, 0 = free
    int       m_owner  [2];   // 0 fetch, 1 opr
    bit       m_flushed[2];
    int       m_starve [2];
    bit [2:0] m_won    [2];   // {wb, opr, fetch} granted this cycle

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) if2 ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) if3 ();

    assign if2.fetch_req = fetch_req;   assign if3.fetch_req = fetch_req;
    assign if2.fetch_addr = fetch_addr; assign if3.fetch_addr = fetch_addr;
    assign if2.fetch_flush = fetch_flush; assign if3.fetch_flush = fetch_flush;
    assign if2.opr_req = opr_req;       assign if3.opr_req = opr_req;
    assign if2.opr_addr = opr_addr;     assign if3.opr_addr = opr_addr;
    assign if2.wb_req = wb_req;         assign if3.wb_req = wb_req;
    assign if2.wb_addr = wb_addr;       assign if3.wb_addr = wb_addr;
    assign if2.wb_wdata = wb_wdata;     assign if3.wb_wdata = wb_wdata;
    assign if2.wb_be = wb_be;           assign if3.wb_be = wb_be;
    assign if2.mem_rdata = mem_rdata;   assign if3.mem_rdata = mem_rdata;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(2), .STARVE_LIMIT(STARVE_LIMIT))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(3), .STARVE_LIMIT(STARVE_LIMIT))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Predict this cycle's outputs for instance k from the rules, compare, advance.
    task automatic model_step(input int k);
        int          lat;
        int          w;
        bit          bad;
        logic [15:0] a;
        logic [2:0]  e_gnt, o_gnt;
        logic [1:0]  e_rv, o_rv, e_be, o_be, e_src, o_src;
        logic [15:0] e_rdata, o_rdata, e_wdata, o_wdata;
        logic [14:0] e_addr, o_addr;
        logic        e_en, o_en, e_we, o_we, e_odd, o_odd;
        string       p;

        lat = (k == 0) ? 2 : 3;
        p   = (k == 0) ? "L2" : "L3";
        e_gnt = '0; e_rv = '0; e_rdata = '0; e_en = 1'b0; e_we = 1'b0;
        e_addr = '0; e_wdata = '0; e_be = '0; e_odd = 1'b0; e_src = '0;
        m_won[k] = '0;
        w = -1;
        a = '0;
        bad = 1'b0;

        if (!rst_n) begin
            m_left[k] = 0; m_starve[k] = 0; m_flushed[k] = 1'b0;
        end else if (m_left[k] > 0) begin
            if (m_owner[k] == 0 && fetch_flush) m_flushed[k] = 1'b1;
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
                if (m_owner[k] == 1) e_rv = 2'b10;
                else if (!m_flushed[k]) e_rv = 2'b01;
                if (e_rv != 2'b00) e_rdata = mem_rdata;
            end
        end else begin
            if (fetch_req && m_starve[k] == STARVE_LIMIT) w = 0;
            else if (wb_req) w = 2;
            else if (opr_req) w = 1;
            else if (fetch_req) w = 0;
            if (w >= 0) begin
                e_gnt    = 3'b001 << w;
                m_won[k] = e_gnt;
                a = (w == 0) ? fetch_addr : (w == 1) ? opr_addr : wb_addr;
                // Word reads/writes need an even address; a lone byte lane must
                // match the address parity (low lane even, high lane odd).
                if (w != 2) bad = a[0];
                else if (wb_be == 2'b11 || wb_be == 2'b01) bad = a[0];
                else if (wb_be == 2'b10) bad = !a[0];
                if (bad) begin
                    e_odd = 1'b1; e_src = 2'(w);
                end else if (w == 2) begin
                    if (wb_be != 2'b00) begin
                        e_en = 1'b1; e_we = 1'b1; e_be = wb_be;
                        e_addr = a[15:1]; e_wdata = wb_wdata;
                    end
                end else begin
                    e_en = 1'b1; e_be = 2'b11; e_addr = a[15:1];
                    m_left[k] = lat; m_owner[k] = w; m_flushed[k] = 1'b0;
                end
                if (w == 0) m_starve[k] = 0;
                else if (fetch_req && m_starve[k] < STARVE_LIMIT) m_starve[k] = m_starve[k] + 1;
            end
        end

        if (k == 0) begin
            o_gnt = {if2.wb_gnt, if2.opr_gnt, if2.fetch_gnt}; o_rv = {if2.opr_rvalid, if2.fetch_rvalid};
            o_rdata = if2.rdata; o_en = if2.mem_en; o_we = if2.mem_we; o_addr = if2.mem_addr;
            o_wdata = if2.mem_wdata; o_be = if2.mem_be; o_odd = if2.odd_err; o_src = if2.odd_err_src;
        end else begin
            o_gnt = {if3.wb_gnt, if3.opr_gnt, if3.fetch_gnt}; o_rv = {if3.opr_rvalid, if3.fetch_rvalid};
            o_rdata = if3.rdata; o_en = if3.mem_en; o_we = if3.mem_we; o_addr = if3.mem_addr;
            o_wdata = if3.mem_wdata; o_be = if3.mem_be; o_odd = if3.odd_err; o_src = if3.odd_err_src;
        end

        chk({p, " gnt"},       32'(o_gnt),   32'(e_gnt));
        chk({p, " rvalid"},    32'(o_rv),    32'(e_rv));
        chk({p, " rdata"},     32'(o_rdata), 32'(e_rdata));
        chk({p, " mem_en"},    32'(o_en),    32'(e_en));
        chk({p, " mem_we"},    32'(o_we),    32'(e_we));
        chk({p, " mem_addr"},  32'(o_addr),  32'(e_addr));
        chk({p, " mem_wdata"}, 32'(o_wdata), 32'(e_wdata));
        chk({p, " mem_be"},    32'(o_be),    32'(e_be));
        chk({p, " odd_err"},   32'(o_odd),   32'(e_odd));
        chk({p, " odd_src"},   32'(o_src),   32'(e_src));
    endtask

    // Move to mid-cycle and run the model against both instances.
    task automatic mid();
        #4;
        model_step(0);
        model_step(1);
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic fin();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mid();
            fin();
        end
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] r;
        r    = 16'($urandom);
        r[0] = ($urandom_range(0, 9) < 3);
        return r;
    endfunction

    initial begin
        logic [15:0] a;
        rst_n = 1'b0; fetch_req = 1'b0; fetch_flush = 1'b0; opr_req = 1'b0; wb_req = 1'b0;
        fetch_addr = '0; opr_addr = '0; wb_addr = '0; wb_wdata = '0; wb_be = 2'b11; mem_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_owner[k] = 0; m_flushed[k] = 1'b0; m_starve[k] = 0; m_won[k] = '0;
        end
        @(posedge clk); #1;

        // Reset: every output zero.
        mid();
        chk("rst gnt", 32'({if2.wb_gnt, if2.opr_gnt, if2.fetch_gnt}), 32'd0);
        chk("rst mem_en", 32'(if2.mem_en), 32'd0);
        fin();
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // Lone fetch at 16'o1000: grant at t, rvalid at t+L, next grant after.
        a = 16'o1000;
        fetch_req = 1'b1; fetch_addr = a;
        mid();
        chk("t1 fetch_gnt", 32'(if2.fetch_gnt), 32'd1);
        chk("t1 mem_addr", 32'(if2.mem_addr), 32'(a >> 1));
        fin();
        fetch_req = 1'b0; opr_req = 1'b1; opr_addr = 16'o4000;
        mid();
        chk("t1 no early rvalid", 32'(if2.fetch_rvalid), 32'd0);
        chk("t1 held off", 32'(if2.opr_gnt), 32'd0);
        fin();
        mem_rdata = 16'hBEEF;
        mid();
        chk("t1 rvalid", 32'(if2.fetch_rvalid), 32'd1);
        chk("t1 rdata", 32'(if2.rdata), 32'hBEEF);
        chk("t1 held off at rvalid", 32'(if2.opr_gnt), 32'd0);
        fin();
        mid();
        chk("t1 next grant t+3", 32'(if2.opr_gnt), 32'd1);
        fin();
        mid();
        chk("t1 L3 next grant t+4", 32'(if3.opr_gnt), 32'd1);
        fin();
        opr_req = 1'b0;
        idle(5);

        // All three requesting, writeback re-requesting: wb x4 then fetch.
        fetch_req = 1'b1; fetch_addr = 16'o3000; opr_req = 1'b1; opr_addr = 16'o4000;
        wb_req = 1'b1; wb_addr = 16'o2000; wb_be = 2'b11; wb_wdata = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("starve wb_gnt", 32'(if2.wb_gnt), 32'd1);
            fin();
        end
        mid();
        chk("starve fetch_gnt", 32'(if2.fetch_gnt), 32'd1);
        chk("starve wb lost", 32'(if2.wb_gnt), 32'd0);
        fin();
        idle(14);
        fetch_req = 1'b0; opr_req = 1'b0; wb_req = 1'b0;
        idle(5);

        // Word write to an odd address.
        wb_req = 1'b1; wb_addr = 16'o2001; wb_be = 2'b11;
        mid();
        chk("oddw odd_err", 32'(if2.odd_err), 32'd1);
        chk("oddw src", 32'(if2.odd_err_src), 32'd2);
        chk("oddw wb_gnt", 32'(if2.wb_gnt), 32'd1);
        chk("oddw mem_en", 32'(if2.mem_en), 32'd0);
        fin();

        // High-byte write to the odd address is legal; low-byte is not.
        wb_be = 2'b10;
        mid();
        chk("hib mem_be", 32'(if2.mem_be), 32'd2);
        chk("hib mem_addr", 32'(if2.mem_addr), 32'o1000);
        chk("hib odd_err", 32'(if2.odd_err), 32'd0);
        fin();
        wb_be = 2'b01;
        mid();
        chk("lob odd_err", 32'(if2.odd_err), 32'd1);
        chk("lob mem_en", 32'(if2.mem_en), 32'd0);
        fin();
        wb_req = 1'b0; wb_be = 2'b11;
        idle(2);

        // Latency 3 fetch flushed at t+1: no rvalid, opr granted at t+4.
        fetch_req = 1'b1; fetch_addr = 16'o1000;
        mid();
        chk("flush fetch_gnt", 32'(if3.fetch_gnt), 32'd1);
        fin();
        fetch_req = 1'b0; fetch_flush = 1'b1; opr_req = 1'b1; opr_addr = 16'o4000;
        mid();
        chk("flush opr held t+1", 32'(if3.opr_gnt), 32'd0);
        fin();
        fetch_flush = 1'b0;
        mid();
        chk("flush L2 no rvalid", 32'(if2.fetch_rvalid), 32'd0);
        fin();
        mid();
        chk("flush L3 no rvalid", 32'(if3.fetch_rvalid), 32'd0);
        chk("flush opr held t+3", 32'(if3.opr_gnt), 32'd0);
        fin();
        mid();
        chk("flush opr gnt t+4", 32'(if3.opr_gnt), 32'd1);
        fin();
        opr_req = 1'b0;
        idle(5);

        // Reset during a read wait abandons it.
        fetch_req = 1'b1; fetch_addr = 16'o1000;
        mid();
        fin();
        fetch_req = 1'b0; rst_n = 1'b0;
        mid();
        chk("rstw rvalid t+1", 32'(if2.fetch_rvalid), 32'd0);
        fin();
        rst_n = 1'b1;
        mid();
        chk("rstw rvalid t+2", 32'(if2.fetch_rvalid), 32'd0);
        chk("rstw L3 mem_en", 32'(if3.mem_en), 32'd0);
        fin();
        opr_req = 1'b1; opr_addr = 16'o4000;
        mid();
        chk("rstw fresh gnt L2", 32'(if2.opr_gnt), 32'd1);
        chk("rstw fresh gnt L3", 32'(if3.opr_gnt), 32'd1);
        fin();
        opr_req = 1'b0;
        idle(5);

        // Randomized traffic; requests held until granted by either instance.
        for (int i = 0; i < 500; i++) begin
            mem_rdata   = 16'($urandom);
            fetch_flush = ($urandom_range(0, 99) < 15);
            rst_n       = ($urandom_range(0, 99) >= 2);
            mid();
            fin();
            if (fetch_req && (m_won[0][0] || m_won[1][0])) fetch_req = 1'b0;
            else if (fetch_req) fetch_req = ($urandom_range(0, 99) >= 5);
            else if ($urandom_range(0, 99) < 40) begin fetch_req = 1'b1; fetch_addr = rand_addr(); end
            if (opr_req && (m_won[0][1] || m_won[1][1])) opr_req = 1'b0;
            else if (opr_req) opr_req = ($urandom_range(0, 99) >= 5);
            else if ($urandom_range(0, 99) < 40) begin opr_req = 1'b1; opr_addr = rand_addr(); end
            if (wb_req && (m_won[0][2] || m_won[1][2])) wb_req = 1'b0;
            else if (wb_req) wb_req = ($urandom_range(0, 99) >= 5);
            else if ($urandom_range(0, 99) < 40) begin
                wb_req = 1'b1; wb_addr = rand_addr(); wb_wdata = 16'($urandom);
                wb_be = 2'($urandom_range(1, 3));
            end
        end
        rst_n = 1'b1; fetch_req = 1'b0; opr_req = 1'b0; wb_req = 1'b0; fetch_flush = 1'b0;
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single unified PDP-11 memory port between three pipeline requesters: instruction fetch (S1), operand read (S2) and result writeback (S4).
- Fixed priority with anti-starvation aging for fetch; one outstanding transaction at a time.
- Detects odd-address word accesses and reports them for the trap logic (vector 4).
- Sits between the pipeline stage logic and the memory model.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (legal range 1..7)
- STARVE_LIMIT, 4, consecutive lost fetch arbitrations before fetch is forced to top priority

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: synchronous, active-low
- fetch_req  in  1  fetch request, held until grant
- fetch_addr  in  ADDR_W  fetch byte address (PC)
- fetch_flush  in  1  discard any in-flight fetch response (taken branch)
- fetch_gnt  out  1  one-cycle grant pulse
- fetch_rvalid  out  1  one-cycle read-data valid pulse
- opr_req  in  1  operand read request
- opr_addr  in  ADDR_W  operand byte address
- opr_gnt  out  1  grant pulse
- opr_rvalid  out  1  read-data valid pulse
- rdata  out  DATA_W  shared read data, qualified by the *_rvalid pulses
- wb_req  in  1  writeback request
- wb_addr  in  ADDR_W  write byte address
- wb_wdata  in  DATA_W  write data
- wb_be  in  2  byte enables: 11 = word, 01 = low byte, 10 = high byte
- wb_gnt  out  1  grant pulse; the write is complete on grant
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W-1  word address (byte address bits [ADDR_W-1:1])
- mem_wdata  out  DATA_W  write data
- mem_be  out  2  byte enables
- mem_rdata  in  DATA_W  memory read data
- odd_err  out  1  odd-address error pulse
- odd_err_src  out  2  error source: 0 = fetch, 1 = opr, 2 = wb

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latency counter and starvation counter cleared.
- FSM states: IDLE and WAIT.
- Arbitration happens only in IDLE.
  - Normal priority: wb > opr > fetch.
  - If starve_cnt == STARVE_LIMIT and fetch_req = 1, priority becomes fetch > wb > opr.
- Grant timing:
  - Grant outputs and the mem_* outputs are combinational in the IDLE cycle t.
  - Exactly one *_gnt is high in that cycle.
- Reads (fetch or opr):
  - At cycle t: mem_en = 1, mem_we = 0, mem_be = 11; go to WAIT.
  - At cycle t + MEM_LATENCY: the owner's rvalid = 1 and rdata = mem_rdata; next state is IDLE.
  - Earliest next grant is t + MEM_LATENCY + 1.
- Writes:
  - At cycle t: mem_en = 1, mem_we = 1, mem_be = wb_be; stay in IDLE.
  - The next grant is possible at t + 1.
- Starvation counter:
  - Increments when fetch_req = 1 in an IDLE cycle and another requester is granted; saturates at STARVE_LIMIT.
  - Clears when fetch is granted.
- Odd-address rule:
  - Applies to any read, or to a write with wb_be = 11, when addr[0] = 1.
  - Response: the grant still pulses, mem_en stays 0, odd_err = 1 and odd_err_src = requester, all in the same cycle.
  - No rvalid follows and the FSM stays in IDLE.
- Byte writes: wb_be = 01 requires addr[0] = 0, and wb_be = 10 requires addr[0] = 1. A mismatch raises odd_err with source 2 and no mem_en.
- wb_be = 00 is illegal. The block asserts in simulation and treats it as a no-op grant.
- fetch_flush:
  - Asserted while a fetch is in WAIT (including the rvalid cycle): fetch_rvalid is suppressed and the FSM still returns to IDLE on schedule.
  - Asserted in IDLE: has no effect.
- Dropping a request:
  - A requester may drop *_req before grant with no effect.
  - Address and data must be stable while the request is high.
- Reset during WAIT: the transaction is abandoned, no rvalid is issued, and the FSM returns to IDLE.
- Simultaneous requests while in WAIT are held off (no grant) and arbitrated on return to IDLE.

Decomposition:
- Shared package `parameters` adds:
  - typedef enum {ARB_IDLE, ARB_WAIT} arb_state_t
  - typedef enum logic [1:0] {REQ_FETCH = 0, REQ_OPR = 1, REQ_WB = 2} mem_req_id_t
  - localparam ODD_ADDR_TRAP_VEC = 16'o4
- One sub-module: arb_priority_sel. It is combinational and takes the req vector and the starve flag, returning a one-hot grant and the requester id.
- The FSM, latency counter and starvation counter live in the top.

Test Plan:
- MEM_LATENCY = 2; fetch_req with addr 16'o1000 alone:
  - grant and mem_addr = 16'o1000 >> 1 at t;
  - fetch_rvalid at t + 2 with rdata = mem_rdata;
  - next grant no earlier than t + 3.
- fetch, opr and wb all requesting continuously (wb always re-requesting): grant order is wb ×4, then fetch once starve_cnt hits 4, with the counter cleared afterwards.
- wb word write to 16'o2001: odd_err = 1, odd_err_src = 2, wb_gnt = 1, mem_en = 0.
- wb byte write with be = 10 to 16'o2001: mem_be = 10, mem_addr = 16'o1000. The same write with be = 01 raises odd_err.
- Fetch granted with MEM_LATENCY = 3 and fetch_flush pulsed at t + 1: no fetch_rvalid; opr request granted at t + 4.
- rst_n low at t + 1 during a read wait: no rvalid; all outputs 0 next cycle; a fresh request is granted the cycle after rst_n returns high.
